// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception controller
//
// Purpose: FSM state encoding and the cause indices of the standard
//          exception sources (index 0 is the highest priority).
// Ports:   none (package)

package exc_pkg;

    typedef enum logic [1:0] {
        EXC_IDLE   = 2'd0,
        EXC_FLUSH  = 2'd1,
        EXC_FROZEN = 2'd2,
        EXC_TRAP   = 2'd3
    } exc_state_e;

    localparam int EXC_ALU_OVF  = 0;
    localparam int EXC_ILLEGAL  = 1;
    localparam int EXC_MEM_ADDR = 2;
    localparam int EXC_SW       = 3;

    localparam int EXC_NUM_STD_SRC = 4;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - lowest-index-wins priority encoder for exception requests
//
// Purpose: reduces the enabled request vector to a single winning index.
// Ports:
//   req   in   NUM_SRC   raw request vector
//   en    in   NUM_SRC   per-source enable mask
//   live  out  1         at least one enabled request present
//   win   out  WIN_W     lowest set index of (req & en); 0 when nothing is live

module exc_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int WIN_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] en,
    output logic               live,
    output logic [WIN_W-1:0]   win
);

    logic [NUM_SRC-1:0] masked;

    assign masked = req & en;
    assign live   = |masked;

    // Scan from the top down so the last hit, i.e. the lowest index, wins.
    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win = WIN_W'(i);
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception controller: prioritise, capture, halt or trap
//
// Purpose: picks the highest-priority enabled exception, captures its PC,
//          instruction and cause, then either freezes the pipeline until the
//          host clears it (TRAP_MODE=0) or issues a one-shot redirect to
//          TRAP_BASE + cause*4 (TRAP_MODE=1).
// Ports:
//   clk, rst     in   clock, synchronous active-high reset
//   excReq/excEn in   per-source request and enable
//   excPc        in   PC of the instruction in execute
//   excInstr     in   instruction in execute
//   excClr       in   host clear, honoured only while frozen
//   exception    out  exception active
//   stall        out  freeze fetch / PC / register-file writes
//   flush        out  one-cycle squash of younger stages
//   trapValid    out  one-cycle redirect strobe
//   trapVector   out  redirect target, valid with trapValid
//   causeOut     out  captured cause index
//   pcOut        out  captured faulting PC
//   instrOut     out  captured faulting instruction
//   pendingMask  out  sticky OR of enabled requests since last clear
//   excCount     out  saturating count of accepted exceptions

module exception_ctrl
    import exc_pkg::*;
#(
    parameter int                NUM_SRC   = EXC_NUM_STD_SRC,
    parameter int                ADDR_W    = 32,
    parameter int                INSTR_W   = 32,
    parameter int                TRAP_MODE = 0,
    parameter logic [ADDR_W-1:0] TRAP_BASE = 'h0000_0100,
    parameter int                CNT_W     = 8,
    parameter int                CAUSE_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] excReq,
    input  logic [NUM_SRC-1:0] excEn,
    input  logic [ADDR_W-1:0]  excPc,
    input  logic [INSTR_W-1:0] excInstr,
    input  logic               excClr,
    output logic               exception,
    output logic               stall,
    output logic               flush,
    output logic               trapValid,
    output logic [ADDR_W-1:0]  trapVector,
    output logic [CAUSE_W-1:0] causeOut,
    output logic [ADDR_W-1:0]  pcOut,
    output logic [INSTR_W-1:0] instrOut,
    output logic [NUM_SRC-1:0] pendingMask,
    output logic [CNT_W-1:0]   excCount
);

    exc_state_e         state;
    exc_state_e         state_next;
    logic               live;
    logic [CAUSE_W-1:0] win;
    logic [NUM_SRC-1:0] masked;
    logic               accept;

    exc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .WIN_W   (CAUSE_W)
    ) u_prio_enc (
        .req  (excReq),
        .en   (excEn),
        .live (live),
        .win  (win)
    );

    assign masked = excReq & excEn;
    assign accept = (state == EXC_IDLE) && live;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EXC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EXC_IDLE: begin
                if (live) begin
                    state_next = EXC_FLUSH;
                end
            end
            EXC_FLUSH: begin
                state_next = (TRAP_MODE != 0) ? EXC_TRAP : EXC_FROZEN;
            end
            EXC_FROZEN: begin
                // Clear wins over a simultaneous request; a held request is
                // picked up again from IDLE on the following cycle.
                if (excClr) begin
                    state_next = EXC_IDLE;
                end
            end
            EXC_TRAP: begin
                state_next = EXC_IDLE;
            end
            default: begin
                state_next = EXC_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        exception  = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        trapValid  = 1'b0;
        trapVector = '0;
        case (state)
            EXC_IDLE: begin
                // Stall in the request cycle itself so the faulting
                // instruction never advances past execute.
                exception = live && !rst;
                stall     = live && !rst;
            end
            EXC_FLUSH: begin
                exception = 1'b1;
                stall     = 1'b1;
                flush     = 1'b1;
            end
            EXC_FROZEN: begin
                exception = 1'b1;
                stall     = 1'b1;
            end
            EXC_TRAP: begin
                exception  = 1'b1;
                trapValid  = 1'b1;
                trapVector = TRAP_BASE + (ADDR_W'(causeOut) << 2);
            end
            default: begin
                exception = 1'b0;
            end
        endcase
    end

    // Capture registers, sticky pending mask and saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            causeOut    <= '0;
            pcOut       <= '0;
            instrOut    <= '0;
            pendingMask <= '0;
            excCount    <= '0;
        end else begin
            if (accept) begin
                causeOut <= win;
                pcOut    <= excPc;
                instrOut <= excInstr;
                if (excCount != {CNT_W{1'b1}}) begin
                    excCount <= excCount + CNT_W'(1);
                end
            end
            if ((state == EXC_FROZEN) && excClr) begin
                pendingMask <= '0;
            end else begin
                pendingMask <= pendingMask | masked;
            end
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl

module tb_exception_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Halt-mode instance signals
    logic        rst, clr;
    logic [3:0]  req, en;
    logic [31:0] pc, instr;
    logic        h_exc, h_stall, h_flush, h_tv;
    logic [31:0] h_tvec, h_pc, h_instr;
    logic [1:0]  h_cause;
    logic [3:0]  h_pend;
    logic [7:0]  h_cnt;

    // Trap-mode instance signals
    logic        t_rst, t_clr;
    logic [3:0]  t_req, t_en;
    logic [31:0] t_pc, t_instr;
    logic        t_exc, t_stall, t_flush, t_tv;
    logic [31:0] t_tvec, t_pco, t_instro;
    logic [1:0]  t_cause;
    logic [3:0]  t_pend;
    logic [7:0]  t_cnt;

    exception_ctrl #(.TRAP_MODE(0)) u_halt (
        .clk(clk), .rst(rst), .excReq(req), .excEn(en), .excPc(pc),
        .excInstr(instr), .excClr(clr), .exception(h_exc), .stall(h_stall),
        .flush(h_flush), .trapValid(h_tv), .trapVector(h_tvec),
        .causeOut(h_cause), .pcOut(h_pc), .instrOut(h_instr),
        .pendingMask(h_pend), .excCount(h_cnt)
    );

    exception_ctrl #(.TRAP_MODE(1)) u_trap (
        .clk(clk), .rst(t_rst), .excReq(t_req), .excEn(t_en), .excPc(t_pc),
        .excInstr(t_instr), .excClr(t_clr), .exception(t_exc), .stall(t_stall),
        .flush(t_flush), .trapValid(t_tv), .trapVector(t_tvec),
        .causeOut(t_cause), .pcOut(t_pco), .instrOut(t_instro),
        .pendingMask(t_pend), .excCount(t_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; t_rst = 1'b1; clr = 1'b0; t_clr = 1'b0;
        req = '0; en = '0; pc = '0; instr = '0;
        t_req = '0; t_en = '0; t_pc = '0; t_instr = '0;
        tick(); tick();
        checks++;
        if ({h_exc, h_stall, h_flush, h_tv} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {h_exc, h_stall, h_flush, h_tv});
        end
        checks++;
        if ({h_pc, h_pend, h_cnt, h_cause} !== '0) begin
            errors++; $display("FAIL reset_regs: pc=%h pend=%b cnt=%h cause=%0d expected all 0", h_pc, h_pend, h_cnt, h_cause);
        end
        checks++;
        if ({t_exc, t_tv, t_tvec, t_cnt} !== '0) begin
            errors++; $display("FAIL reset_trap: exc=%b tv=%b tvec=%h cnt=%h expected all 0", t_exc, t_tv, t_tvec, t_cnt);
        end
        rst = 1'b0; t_rst = 1'b0;
        tick();
    endtask

    task automatic test_halt_capture();
        en = 4'hF; req = 4'b0001; pc = 32'h40; instr = 32'hC2B74000;
        #1;
        checks++;
        if ({h_exc, h_stall, h_flush} !== 3'b110) begin
            errors++; $display("FAIL same_cycle_exc: got exc/stall/flush=%b expected 110", {h_exc, h_stall, h_flush});
        end
        tick();
        req = '0; pc = 32'h44; instr = 32'h0;
        #1;
        checks++;
        if ({h_exc, h_stall, h_flush} !== 3'b111) begin
            errors++; $display("FAIL flush_cycle: got exc/stall/flush=%b expected 111", {h_exc, h_stall, h_flush});
        end
        checks++;
        if (h_cnt !== 8'd1 || h_cause !== 2'd0) begin
            errors++; $display("FAIL first_capture: cnt=%0d cause=%0d expected cnt=1 cause=0", h_cnt, h_cause);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            pc = pc + 32'h4; instr = instr + 32'h1;
            #1;
            checks++;
            if (h_pc !== 32'h40 || h_instr !== 32'hC2B74000 || {h_exc, h_stall, h_flush} !== 3'b110) begin
                errors++;
                $display("FAIL frozen_hold[%0d]: pc=%h instr=%h ctrl=%b expected pc=00000040 instr=c2b74000 ctrl=110",
                         i, h_pc, h_instr, {h_exc, h_stall, h_flush});
            end
        end
        checks++;
        if (h_pend !== 4'b0001) begin
            errors++; $display("FAIL frozen_pend: got %b expected 0001", h_pend);
        end
    endtask

    task automatic test_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (h_exc !== 1'b0 || h_stall !== 1'b0 || h_pend !== 4'b0000) begin
            errors++; $display("FAIL clear_idle: exc=%b stall=%b pend=%b expected 0 0 0000", h_exc, h_stall, h_pend);
        end
        checks++;
        if (h_cnt !== 8'd1 || h_pc !== 32'h40) begin
            errors++; $display("FAIL clear_hold: cnt=%0d pc=%h expected 1 00000040", h_cnt, h_pc);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (h_exc !== 1'b0 || h_cnt !== 8'd1) begin
            errors++; $display("FAIL clear_in_idle: exc=%b cnt=%0d expected 0 1", h_exc, h_cnt);
        end
    endtask

    task automatic test_simultaneous();
        req = 4'b1010; pc = 32'h80; instr = 32'hDEADBEEF;
        #1;
        checks++;
        if (h_exc !== 1'b1) begin
            errors++; $display("FAIL multi_exc: got %b expected 1", h_exc);
        end
        tick();
        req = '0;
        tick();
        checks++;
        if (h_cause !== 2'd1 || h_pend !== 4'b1010 || h_cnt !== 8'd2 || h_pc !== 32'h80) begin
            errors++; $display("FAIL multi_capture: cause=%0d pend=%b cnt=%0d pc=%h expected 1 1010 2 00000080",
                               h_cause, h_pend, h_cnt, h_pc);
        end
        req = 4'b0100;
        tick();
        req = '0;
        #1;
        checks++;
        if (h_pend !== 4'b1110 || h_cause !== 2'd1 || h_cnt !== 8'd2 || h_exc !== 1'b1) begin
            errors++; $display("FAIL frozen_new_req: pend=%b cause=%0d cnt=%0d exc=%b expected 1110 1 2 1",
                               h_pend, h_cause, h_cnt, h_exc);
        end
        req = 4'b0001; clr = 1'b1; pc = 32'hC0;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (h_pend !== 4'b0000 || h_exc !== 1'b1 || h_flush !== 1'b0) begin
            errors++; $display("FAIL clr_with_req: pend=%b exc=%b flush=%b expected 0000 1 0", h_pend, h_exc, h_flush);
        end
        tick();
        req = '0;
        #1;
        checks++;
        if (h_flush !== 1'b1 || h_cause !== 2'd0 || h_pc !== 32'hC0 || h_cnt !== 8'd3 || h_pend !== 4'b0001) begin
            errors++; $display("FAIL reeval_capture: flush=%b cause=%0d pc=%h cnt=%0d pend=%b expected 1 0 000000c0 3 0001",
                               h_flush, h_cause, h_pc, h_cnt, h_pend);
        end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (h_exc !== 1'b0) begin
            errors++; $display("FAIL reeval_clear: exc=%b expected 0", h_exc);
        end
    endtask

    task automatic test_trap();
        t_en = 4'hF; t_req = 4'b0100; t_pc = 32'h200; t_instr = 32'h1234_5678;
        #1;
        checks++;
        if ({t_exc, t_stall, t_tv} !== 3'b110) begin
            errors++; $display("FAIL trap_req_cycle: exc/stall/tv=%b expected 110", {t_exc, t_stall, t_tv});
        end
        tick();
        t_req = '0;
        #1;
        checks++;
        if (t_flush !== 1'b1 || t_tv !== 1'b0) begin
            errors++; $display("FAIL trap_flush: flush=%b tv=%b expected 1 0", t_flush, t_tv);
        end
        tick();
        t_req = 4'b0001;
        #1;
        checks++;
        if (t_tv !== 1'b1 || t_tvec !== 32'h108 || t_stall !== 1'b0 || t_exc !== 1'b1 || t_flush !== 1'b0) begin
            errors++; $display("FAIL trap_strobe: tv=%b vec=%h stall=%b exc=%b flush=%b expected 1 00000108 0 1 0",
                               t_tv, t_tvec, t_stall, t_exc, t_flush);
        end
        tick();
        t_req = '0;
        #1;
        checks++;
        if (t_tv !== 1'b0 || t_stall !== 1'b0 || t_exc !== 1'b0) begin
            errors++; $display("FAIL trap_after: tv=%b stall=%b exc=%b expected 0 0 0", t_tv, t_stall, t_exc);
        end
        checks++;
        if (t_cnt !== 8'd1 || t_cause !== 2'd2 || t_pend !== 4'b0101 || t_pco !== 32'h200) begin
            errors++; $display("FAIL trap_ignore_req: cnt=%0d cause=%0d pend=%b pc=%h expected 1 2 0101 00000200",
                               t_cnt, t_cause, t_pend, t_pco);
        end
    endtask

    task automatic test_disabled();
        en = 4'b1110; req = 4'b0001;
        #1;
        checks++;
        if (h_exc !== 1'b0 || h_stall !== 1'b0) begin
            errors++; $display("FAIL disabled_exc: exc=%b stall=%b expected 0 0", h_exc, h_stall);
        end
        tick();
        req = '0;
        #1;
        checks++;
        if (h_pend !== 4'b0000 || h_cnt !== 8'd3 || h_flush !== 1'b0) begin
            errors++; $display("FAIL disabled_regs: pend=%b cnt=%0d flush=%b expected 0000 3 0", h_pend, h_cnt, h_flush);
        end
        en = 4'hF;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 259; i++) begin
            req = 4'b0001;
            tick();
            req = '0;
            tick();
            clr = 1'b1;
            tick();
            clr = 1'b0;
            if (i == 250) begin
                checks++;
                if (h_cnt !== 8'hFE) begin
                    errors++; $display("FAIL count_fe: got %h expected fe", h_cnt);
                end
            end
            if (i == 251) begin
                checks++;
                if (h_cnt !== 8'hFF) begin
                    errors++; $display("FAIL count_ff: got %h expected ff", h_cnt);
                end
            end
        end
        checks++;
        if (h_cnt !== 8'hFF) begin
            errors++; $display("FAIL count_saturated: got %h expected ff", h_cnt);
        end
    endtask

    task automatic test_reset_flush();
        req = 4'b0001; pc = 32'h300; instr = 32'hABCD_0001;
        tick();
        req = '0;
        #1;
        checks++;
        if (h_flush !== 1'b1) begin
            errors++; $display("FAIL pre_reset_flush: got %b expected 1", h_flush);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({h_exc, h_stall, h_flush, h_tv} !== 4'b0000 || h_tvec !== 32'h0 || h_cause !== 2'd0) begin
            errors++; $display("FAIL reset_in_flush_ctrl: ctrl=%b vec=%h cause=%0d expected 0000 0 0",
                               {h_exc, h_stall, h_flush, h_tv}, h_tvec, h_cause);
        end
        checks++;
        if (h_pc !== 32'h0 || h_instr !== 32'h0 || h_pend !== 4'h0 || h_cnt !== 8'h0) begin
            errors++; $display("FAIL reset_in_flush_regs: pc=%h instr=%h pend=%b cnt=%h expected all 0",
                               h_pc, h_instr, h_pend, h_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (h_exc !== 1'b0 || h_flush !== 1'b0) begin
            errors++; $display("FAIL after_reset_idle: exc=%b flush=%b expected 0 0", h_exc, h_flush);
        end
    endtask

    initial begin
        test_reset();
        test_halt_capture();
        test_clear();
        test_simultaneous();
        test_trap();
        test_disabled();
        test_saturation();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
